rom_burst_reader: RTL and testbench

//  Parametrised successor to the single-address ROM read path: fetches a burst of LEN

---
 rtl/rom_burst_reader.sv | 187 ++++++++++++++++++
 tb/tb_rom_burst_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// Burst reader: streams LEN consecutive words from a synchronous ROM over valid/ready.
// Define RD_CHECKSUM_EN to add a per-burst XOR checksum of all delivered words.
module rom_burst_reader #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  start_len,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_rden,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int DEPTH = ROM_LAT + 1;
    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  issue_cnt;
    logic [ROM_LAT-1:0] rd_pipe;
    logic [ROM_LAT-1:0] last_pipe;

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  mem_l;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  inflight;

    logic accept;
    logic pop;
    logic push;
    logic credit_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign accept      = start_valid & start_ready;
    assign pop         = out_valid & out_ready;
    assign push        = rd_pipe[ROM_LAT-1];
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign rom_address = cur_addr;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CNT_W'(rd_pipe[i]);
        end
    end

    // A word popped this cycle frees its slot for a read issued this cycle.
    assign credit_ok = (inflight + fifo_cnt - CNT_W'(pop)) < CNT_W'(DEPTH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rom_rden  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (start_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    rom_rden = 1'b1;
                    if (issue_cnt == LEN_W'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr  <= '0;
            issue_cnt <= '0;
            rd_pipe   <= '0;
            last_pipe <= '0;
        end else begin
            if (accept) begin
                cur_addr  <= start_addr;
                issue_cnt <= start_len;
            end else if (rom_rden) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                issue_cnt <= issue_cnt - LEN_W'(1);
            end
            // Tag each read with its last-word flag so it travels with the data.
            rd_pipe[0]   <= rom_rden;
            last_pipe[0] <= rom_rden && (issue_cnt == LEN_W'(1));
            for (int i = 1; i < ROM_LAT; i++) begin
                rd_pipe[i]   <= rd_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            mem_l    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_d[wr_ptr] <= rom_data;
                mem_l[wr_ptr] <= last_pipe[ROM_LAT-1];
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = mem_d[rd_ptr];
    assign out_last  = mem_l[rd_ptr] & out_valid;

`ifdef RD_CHECKSUM_EN
    logic [DATA_W-1:0] cs_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_q <= '0;
        end else if (accept) begin
            cs_q <= '0;
        end else if (pop) begin
            cs_q <= cs_q ^ out_data;
        end
    end

    assign checksum = cs_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: vector table, random bursts and reset/checksum sequences.
// Expected words, addresses, flags and checksums come from a ROM array model.
module tb_rom_burst_reader;

    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 16;
    localparam int LEN_W   = 8;
    localparam int ROM_LAT = 1;
    localparam int NWORDS  = 1 << ADDR_W;
    localparam int FIRST   = ROM_LAT + 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start_valid = 1'b0;
    logic              start_ready;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [LEN_W-1:0]  start_len = '0;
    logic [ADDR_W-1:0] rom_address;
    logic              rom_rden;
    logic [DATA_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    logic [DATA_W-1:0] rom [NWORDS];
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [ADDR_W-1:0] addr_log [$];

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        int                mode;
        int                first_valid;
    } vec_t;

    vec_t vecs [7];

    always #5 clock = ~clock;

    rom_burst_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .ROM_LAT(ROM_LAT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_addr (start_addr),
        .start_len  (start_len),
        .rom_address(rom_address),
        .rom_rden   (rom_rden),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always @(posedge clock) begin
        if (rom_rden) begin
            d1 <= rom[rom_address];
            addr_log.push_back(rom_address);
        end
        d2 <= d1;
    end

    assign rom_data = (ROM_LAT == 1) ? d1 : d2;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start_ready"}, start_ready, 1);
        chk({tag, "_rom_address"}, rom_address, 0);
        chk({tag, "_rom_rden"}, rom_rden, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    function automatic logic rdy(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                             input int mode, input int first_valid);
        int got, cyc, first_cyc, last_cyc, done_cyc, nvalid;
        logic [DATA_W-1:0] cs;
        logic [DATA_W-1:0] prev_d;
        logic [ADDR_W-1:0] ea;
        logic prev_l, prev_stall;
        got = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; nvalid = 0;
        cs = '0; prev_d = '0; prev_l = 1'b0; prev_stall = 1'b0;
        @(negedge clock);
        addr_log.delete();
        start_valid = 1'b1;
        start_addr  = a;
        start_len   = l;
        out_ready   = rdy(mode, 0);
        #1 chk("start_ready_idle", start_ready, 1);
        @(negedge clock);
        start_valid = 1'b0;
        start_addr  = ADDR_W'($urandom);
        start_len   = LEN_W'($urandom);
        cyc = 1;
        while (done_cyc < 0 && cyc < 600) begin
            out_ready = rdy(mode, cyc);
            #1;
            chk("busy", busy, 1);
            chk("start_ready_busy", start_ready, 0);
            if (out_valid) begin
                nvalid++;
                if (first_cyc < 0) first_cyc = cyc;
                if (prev_stall) begin
                    chk("stall_data", out_data, prev_d);
                    chk("stall_last", out_last, prev_l);
                end
            end else if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                ea = a + ADDR_W'(got);
                chk("word", out_data, rom[ea]);
                chk("last", out_last, got == int'(l) - 1);
                cs = cs ^ out_data;
                got++;
                if (out_last) last_cyc = cyc;
            end
            if (done) done_cyc = cyc;
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            if (done_cyc < 0) begin
                @(negedge clock);
                cyc++;
            end
        end
        chk("done_seen", done_cyc >= 0, 1);
`ifdef RD_CHECKSUM_EN
        chk("checksum", checksum, cs);
`else
        chk("checksum_off", checksum, 0);
`endif
        chk("word_count", got, l);
        chk("rden_count", addr_log.size(), l);
        for (int i = 0; i < addr_log.size(); i++) begin
            ea = a + ADDR_W'(i);
            chk("rom_addr", addr_log[i], ea);
        end
        if (l == 0) begin
            chk("empty_no_valid", nvalid, 0);
            chk("empty_done_cyc", done_cyc, 1);
        end else begin
            chk("done_after_last", done_cyc, last_cyc + 1);
            if (first_valid > 0) chk("latency", first_cyc, first_valid);
            if (mode == 0) chk("throughput", last_cyc - first_cyc, int'(l) - 1);
        end
        @(negedge clock);
        #1;
        chk("done_pulse_end", done, 0);
        chk("back_idle", busy, 0);
        chk("ready_again", start_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, cyc, mode;
        vecs[0] = '{13'h0000, 8'd4,   0, FIRST};
        vecs[1] = '{13'h1FFE, 8'd4,   0, FIRST};
        vecs[2] = '{13'h0040, 8'd8,   1, 0};
        vecs[3] = '{13'h0123, 8'd0,   0, 0};
        vecs[4] = '{13'h1FFF, 8'd1,   0, FIRST};
        vecs[5] = '{13'h0800, 8'd255, 0, FIRST};
        vecs[6] = '{13'h0010, 8'd12,  2, 0};

        for (int i = 0; i < NWORDS; i++) rom[i] = DATA_W'($urandom);

        #1 chk_reset_vals("reset");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].first_valid);
        end

        for (int i = 0; i < 12; i++) begin
            mode = $urandom_range(0, 2);
            run_burst(ADDR_W'($urandom), LEN_W'($urandom_range(0, 24)), mode,
                      (mode == 0) ? FIRST : 0);
        end

        @(negedge clock);
        start_valid = 1'b1;
        start_addr  = 13'h0200;
        start_len   = 8'd16;
        out_ready   = 1'b1;
        @(negedge clock);
        start_valid = 1'b0;
        got = 0;
        cyc = 0;
        while (cyc < 100 && got < 3) begin
            #1;
            if (out_valid && out_ready) got++;
            @(negedge clock);
            cyc++;
        end
        chk("reset_reached_word3", got, 3);
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("midburst_reset");
        @(negedge clock);
        reset_n = 1'b1;
        run_burst(13'h0100, 8'd2, 0, FIRST);

        rom[13'h0300] = 16'h1234;
        rom[13'h0301] = 16'h00FF;
        rom[13'h0302] = 16'hF000;
        run_burst(13'h0300, 8'd3, 0, FIRST);
`ifdef RD_CHECKSUM_EN
        chk("checksum_e2cb", checksum, 16'hE2CB);
`else
        chk("checksum_tied_zero", checksum, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
